// File: rtl/bus_seq_pkg.sv
// Shared definitions for the bus transfer sequencer: FSM state encoding
// and the request legality rule.
package bus_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      XFER  = 3'd2,
      TURN  = 3'd3,
      ERR   = 3'd4
   } state_e;

   localparam int unsigned CNT_W = 8;

   // A transfer needs two distinct, existing registers.
   function automatic logic req_legal(input int unsigned src,
                                      input int unsigned dst,
                                      input int unsigned nreg);
      return (src != dst) && (src < nreg) && (dst < nreg);
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index-plus-enable to one-hot decoder; output is all-zero when disabled.
module onehot_decoder #(
   parameter int unsigned NREG = 8,
   parameter int unsigned IDXW = 3
) (
   input  logic            en,
   input  logic [IDXW-1:0] idx,
   output logic [NREG-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (en && (32'(idx) == i)) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences register-to-register bus transfers: drive source, load
// destination, then a turnaround cycle so two drivers never overlap.
module bus_transfer_sequencer
   import bus_seq_pkg::*;
#(
   parameter int unsigned NREG = 8,
   parameter int unsigned IDXW = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IDXW-1:0]  req_src,
   input  logic [IDXW-1:0]  req_dst,
   input  logic             abort,
   output logic [NREG-1:0]  oe,
   output logic [NREG-1:0]  load,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] xfer_count
);

   state_e           state_q, state_d;
   logic [IDXW-1:0]  src_q, src_d;
   logic [IDXW-1:0]  dst_q, dst_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NREG-1:0]  oe_q, oe_d;
   logic [NREG-1:0]  load_q, load_d;
   logic             oe_en_d;
   logic             load_en_d;
   logic             accept;

   assign accept = req_valid && ready_q && !abort;

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cnt_d     = cnt_q;
      oe_en_d   = 1'b0;
      load_en_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            // An abort while idle holds the handshake exactly where it was.
            ready_d = abort ? ready_q : 1'b1;
            if (accept) begin
               src_d   = req_src;
               dst_d   = req_dst;
               ready_d = 1'b0;
               if (req_legal(32'(req_src), 32'(req_dst), NREG)) begin
                  state_d = DRIVE;
                  oe_en_d = 1'b1;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
         DRIVE: begin
            if (abort) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               state_d   = XFER;
               oe_en_d   = 1'b1;
               load_en_d = 1'b1;
            end
         end
         XFER: begin
            state_d = abort ? IDLE : TURN;
            ready_d = abort;
            if (!abort) begin
               done_d = 1'b1;
               cnt_d  = cnt_q + 8'd1;
            end
         end
         TURN: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         ERR: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b0;
         end
      endcase
   end

   // Strobes are decoded from next-state indices so they come straight off flops.
   onehot_decoder #(.NREG(NREG), .IDXW(IDXW)) u_oe_dec (
      .en     (oe_en_d),
      .idx    (src_d),
      .onehot (oe_d)
   );

   onehot_decoder #(.NREG(NREG), .IDXW(IDXW)) u_load_dec (
      .en     (load_en_d),
      .idx    (dst_d),
      .onehot (load_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         oe_q    <= '0;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         oe_q    <= oe_d;
         load_q  <= load_d;
      end
   end

   assign req_ready  = ready_q;
   assign oe         = oe_q;
   assign load       = load_q;
   assign done       = done_q;
   assign err        = err_q;
   assign xfer_count = cnt_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: stimulus queues expected bus cycles and done/err events,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_bus_transfer_sequencer;

   localparam int unsigned NREG = 8;
   localparam int unsigned IDXW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [IDXW-1:0] req_src = '0;
   logic [IDXW-1:0] req_dst = '0;
   logic            abort = 1'b0;
   logic [NREG-1:0] oe;
   logic [NREG-1:0] load;
   logic            done;
   logic            err;
   logic [7:0]      xfer_count;

   bus_transfer_sequencer #(.NREG(NREG), .IDXW(IDXW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_src    (req_src),
      .req_dst    (req_dst),
      .abort      (abort),
      .oe         (oe),
      .load       (load),
      .done       (done),
      .err        (err),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] oe;
      logic [7:0] load;
   } bus_t;

   typedef struct packed {
      logic       is_err;
      logic [7:0] cnt;
   } ev_t;

   bus_t       bus_q[$];
   ev_t        ev_q[$];
   int         checks = 0;
   int         failures = 0;
   int         run_len = 0;
   logic [7:0] exp_cnt = 8'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor
   always @(negedge clk) begin : monitor
      bus_t b;
      ev_t  e;
      if (rst_n === 1'b1) begin
         if (oe !== '0 || load !== '0) begin
            if (bus_q.size() == 0) begin
               chk("bus_unexpected", {16'h0, oe, load}, 32'h0);
            end else begin
               b = bus_q.pop_front();
               chk("oe", oe, b.oe);
               chk("load", load, b.load);
            end
         end
         if (oe !== '0) begin
            run_len++;
         end else if (run_len != 0) begin
            chk("oe_run_len", run_len, 2);
            run_len = 0;
         end
         if (done || err) begin
            if (ev_q.size() == 0) begin
               chk("event_unexpected", {30'h0, done, err}, 32'h0);
            end else begin
               e = ev_q.pop_front();
               chk("event_err", err, e.is_err);
               chk("event_done", done, !e.is_err);
               chk("event_count", xfer_count, e.cnt);
            end
         end
      end else begin
         run_len = 0;
      end
   end

   task automatic push_xfer(input logic [3:0] s, input logic [3:0] d);
      bus_t b;
      ev_t  e;
      exp_cnt  = exp_cnt + 8'd1;
      b.oe     = 8'b1 << s;
      b.load   = 8'h00;
      bus_q.push_back(b);
      b.load   = 8'b1 << d;
      bus_q.push_back(b);
      e.is_err = 1'b0;
      e.cnt    = exp_cnt;
      ev_q.push_back(e);
   endtask

   task automatic do_xfer(input logic [3:0] s, input logic [3:0] d);
      int n;
      bit seen;
      push_xfer(s, d);
      req_src   = s;
      req_dst   = d;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_src   = ~s;
      req_dst   = ~d;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 8) begin
         @(posedge clk); #1;
         n++;
         if (done) seen = 1'b1;
      end
      chk("done_latency", seen ? n : 99, 2);
      @(posedge clk); #1;
      chk("ready_after_turn", req_ready, 1);
   endtask

   task automatic do_illegal(input logic [3:0] s, input logic [3:0] d);
      ev_t e;
      e.is_err  = 1'b1;
      e.cnt     = exp_cnt;
      ev_q.push_back(e);
      req_src   = s;
      req_dst   = d;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("illegal_err", err, 1);
      chk("illegal_ready_low", req_ready, 0);
      chk("illegal_oe", oe, 0);
      @(posedge clk); #1;
      chk("illegal_err_clear", err, 0);
      chk("illegal_ready_back", req_ready, 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int t[3];
      int rises;
      int n;
      logic [7:0] prev_oe;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_oe", oe, 0);
      chk("rst_load", load, 0);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_count", xfer_count, 0);
      #2 rst_n = 1'b1;
      #1 chk("ready_before_edge", req_ready, 0);
      @(posedge clk); #1;
      chk("ready_after_release", req_ready, 1);
      chk("release_outputs", {oe, load, done, err, xfer_count}, 0);

      do_xfer(4'd2, 4'd5);
      chk("count_after_first", xfer_count, 1);

      for (int i = 0; i < 3; i++) push_xfer(4'd1, 4'd6);
      req_src   = 4'd1;
      req_dst   = 4'd6;
      req_valid = 1'b1;
      rises   = 0;
      n       = 0;
      prev_oe = 8'h00;
      t       = '{0, 0, 0};
      while (rises < 3 && n < 30) begin
         @(posedge clk); #1;
         n++;
         if (oe != 8'h00 && prev_oe == 8'h00) begin
            t[rises] = n;
            rises++;
         end
         prev_oe = oe;
      end
      req_valid = 1'b0;
      chk("b2b_accepts", rises, 3);
      chk("b2b_gap1", t[1] - t[0], 4);
      chk("b2b_gap2", t[2] - t[1], 4);
      repeat (4) @(posedge clk);
      #1;
      chk("b2b_count", xfer_count, exp_cnt);

      do_illegal(4'd3, 4'd3);
      do_illegal(4'd9, 4'd0);
      do_illegal(4'd0, 4'd12);
      chk("illegal_count", xfer_count, exp_cnt);

      req_src   = 4'd0;
      req_dst   = 4'd1;
      req_valid = 1'b1;
      abort     = 1'b1;
      @(posedge clk); #1;
      chk("idle_abort_ready", req_ready, 1);
      chk("idle_abort_oe", oe, 0);
      abort     = 1'b0;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_abort_no_accept", oe, 0);

      begin
         bus_t b;
         b.oe   = 8'h10;
         b.load = 8'h00;
         bus_q.push_back(b);
         b.load = 8'h01;
         bus_q.push_back(b);
      end
      req_src   = 4'd4;
      req_dst   = 4'd0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("xfer_load", load, 8'h01);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_load_clear", load, 0);
      chk("abort_oe_clear", oe, 0);
      chk("abort_ready", req_ready, 1);
      chk("abort_no_done", done, 0);
      chk("abort_count", xfer_count, exp_cnt);
      repeat (3) @(posedge clk);
      #1;

      for (int i = 0; i < 252; i++) begin
         do_xfer(4'(i % 8), 4'((i + 3) % 8));
      end
      chk("wrap_model", {24'h0, exp_cnt}, 32'h0);
      chk("wrap_count", xfer_count, 0);

      req_src   = 4'd3;
      req_dst   = 4'd6;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("drive_oe", oe, 8'h08);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_oe", oe, 0);
      chk("async_rst_load", load, 0);
      chk("async_rst_ready", req_ready, 0);
      #3 rst_n = 1'b1;
      exp_cnt = 8'd0;
      @(posedge clk); #1;
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_oe", oe, 0);
      repeat (3) @(posedge clk);
      #1;

      chk("bus_queue_empty", bus_q.size(), 0);
      chk("event_queue_empty", ev_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_transfer_sequencer.md
BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

Interface
REQ-001 SHALL have parameter NREG, default 8, giving the number of bus registers controlled (2..16).
REQ-002 SHALL have parameter IDXW, default $clog2(NREG), giving the width of the register index.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  transfer request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_src  input  IDXW  index of the source register that drives the bus.
REQ-008 SHALL have port req_dst  input  IDXW  index of the destination register that loads from the bus.
REQ-009 SHALL have port abort  input  1  synchronous cancel of an in-flight transfer.
REQ-010 SHALL have port oe  output  NREG  one-hot output_enable strobes, one per register.
REQ-011 SHALL have port load  output  NREG  one-hot load strobes, one per register.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a transfer completes.
REQ-013 SHALL have port err  output  1  one-cycle pulse when a request is rejected.
REQ-014 SHALL have port xfer_count  output  8  number of completed transfers, wrapping.

Function
REQ-015 SHALL drive every output from a flop; there are no combinational input-to-output paths.
REQ-016 SHALL use the FSM states IDLE, DRIVE, XFER, TURN and ERR.
REQ-017 SHALL accept a request at a clock edge where req_valid=1, req_ready=1 and abort=0.
REQ-018 SHALL, on accepting a valid request, move IDLE to DRIVE with oe[src]=1, load=0 and req_ready=0.
REQ-019 SHALL move DRIVE to XFER with oe[src]=1 and load[dst]=1; the destination register captures at the end of XFER.
REQ-020 SHALL move XFER to TURN with oe=0, load=0, done=1 and xfer_count incremented by 1 (255 wraps to 0).
REQ-021 SHALL move TURN to IDLE with done=0 and req_ready=1.
REQ-022 SHALL therefore give a latency from accept edge to done of 3 edges and a throughput of 1 transfer per 4 cycles.
REQ-023 SHALL treat a request as illegal when src==dst, src>=NREG or dst>=NREG.
REQ-024 SHALL, on accepting an illegal request, move IDLE to ERR with err=1 and req_ready=0, then move ERR to IDLE with err=0 and req_ready=1; oe and load stay 0.
REQ-025 SHALL, when abort=1 at an edge in DRIVE or XFER, go to IDLE with oe=0, load=0 and req_ready=1, with no done pulse and no count change.
REQ-026 SHALL ignore abort in TURN and ERR.
REQ-027 SHALL not accept a request when abort=1 in IDLE, and SHALL leave req_ready unchanged.
REQ-028 SHALL never assert more than one bit of oe, or more than one bit of load, in any cycle.
REQ-029 SHALL guarantee at least one cycle with oe all-zero between any two transfers, so there is no bus contention.
REQ-030 SHALL latch req_src and req_dst at the accept edge; input changes afterwards are ignored.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE, oe=0, load=0, done=0, err=0, xfer_count=0 and req_ready=0.
REQ-032 SHALL set req_ready=1 at the first rising edge after rst_n deasserts.
REQ-033 SHALL, on reset asserted mid-transfer, clear oe and load immediately, without waiting for a clock.

Structure
REQ-034 SHALL take the state enum and the state encoding from the shared package bus_seq_pkg.
REQ-035 SHALL use a single sub-module, onehot_decoder (index plus enable to NREG-bit one-hot), instantiated twice: once for oe and once for load.

Verification
REQ-036 SHALL cover reset release: req_ready=0 during reset and 1 one edge after rst_n rises; all other outputs 0.
REQ-037 SHALL cover a legal request src=2, dst=5: oe=0x04 for 2 cycles, load=0x20 in the second of them, done=1 on the 3rd edge, xfer_count=1.
REQ-038 SHALL cover back-to-back requests with req_valid held high: accepts 4 cycles apart, with an oe=0 gap between them.
REQ-039 SHALL cover illegal requests src=3, dst=3 and src=9 (NREG=8): one err pulse each, oe and load never asserted, count unchanged.
REQ-040 SHALL cover abort asserted in XFER: load cleared next cycle, no done pulse, count unchanged, req_ready=1.
REQ-041 SHALL cover 256 completed transfers: xfer_count wraps to 0, and a reset mid-DRIVE clears oe asynchronously.
